debounce_ctrl: RTL
==================

// Module: debounce_ctrl
// PURPOSE
//  Debounces one asynchronous input (button/switch) by driving an external timer
//  instance over its start/done interface: arms the timer on an input change, commits
//  the new level when the timer expires without the input reverting. Sits directly
//  upstream of the timer (drives start, consumes done); clean level and edge pulses go
//  to downstream logic.
// PARAMETERS
//  SYNC_STAGES  2        synchroniser flops on raw_in (legal >= 2)
//  RESET_LEVEL  1'b0     value of sync chain and clean_out after reset
//  GLITCH_W     8        width of saturating glitch counter
//  WDOG_LIMIT   65535    max cycles in WAIT/DRAIN before fault; 0 disables watchdog
//  WDOG_W       16       watchdog counter width (must hold WDOG_LIMIT)
// PORTS
//  clk          in   1         clock
//  rst          in   1         reset, synchronous, active-high
//  raw_in       in   1         asynchronous bouncy input
//  tmr_start    out  1         one-cycle start pulse to the timer
//  tmr_done     in   1         timer expiry from the timer (level or pulse; rising edge used)
//  clean_out    out  1         debounced level
//  rise_pulse   out  1         1 cycle high when clean_out goes 0->1
//  fall_pulse   out  1         1 cycle high when clean_out goes 1->0
//  glitch_cnt   out  GLITCH_W  count of aborted debounce attempts, saturates at all-ones
//  wdog_err     out  1         sticky: timer never answered within WDOG_LIMIT cycles
// BEHAVIOUR
//  Reset: sync chain = RESET_LEVEL, clean_out = RESET_LEVEL, tmr_start = rise_pulse =
//   fall_pulse = 0, glitch_cnt = 0, wdog_err = 0, state = STABLE, done-edge reg = 0.
//   The timer's active-low reset is tied to ~rst so both restart together.
//  done_ev = tmr_done & ~tmr_done_q (registered rising edge); only done_ev is acted on.
//  sync_in = last stage of synchroniser. All outputs are registered.
//  FSM:
//   STABLE: sync_in != clean_out -> tmr_start=1 for exactly one cycle, go WAIT, clear wdog.
//           done_ev ignored in STABLE.
//   WAIT:   sync_in == clean_out -> glitch_cnt+1 (sat); go DRAIN (timer still running),
//             unless done_ev in the same cycle -> go STABLE (done already consumed).
//           else done_ev -> clean_out <= sync_in, matching rise/fall pulse, go STABLE.
//   DRAIN:  done_ev -> go STABLE (re-evaluates input next cycle). tmr_start never
//           asserted while a timer run is outstanding.
//   Watchdog (WDOG_LIMIT != 0): counter runs in WAIT/DRAIN, cleared on entry; at
//   WDOG_LIMIT -> wdog_err <= 1 (sticky until rst), state STABLE, clean_out unchanged.
//  Latency: with timer count N, first edge sampling new raw_in = edge 0: tmr_start
//   high after edge SYNC_STAGES; clean_out and edge pulse change at edge SYNC_STAGES+N+2.
//  rise_pulse/fall_pulse never both high; never high without a clean_out change.
//  Reset mid-operation: any state returns to STABLE; pulses drop the same edge.
// TESTING (SYNC_STAGES=2, behavioural timer N=10, RESET_LEVEL=0)
//  1. raw_in 0->1 held -> one tmr_start after edge 2; clean_out=1 and rise_pulse one
//     cycle at edge 14; glitch_cnt=0.
//  2. raw_in high 4 cycles then low -> glitch_cnt=1, state DRAIN until done, clean_out
//     stays 0, no pulses, exactly one tmr_start.
//  3. Glitch then raw_in high held while draining -> second tmr_start only after stale
//     done; clean_out=1 N+2 edges after that start; glitch_cnt=1.
//  4. Input reverts in same cycle done_ev arrives -> glitch counted, back to STABLE,
//     no DRAIN, clean_out unchanged; 300 glitches -> glitch_cnt=255 (sat).
//  5. WDOG_LIMIT=50, timer model never asserts done -> wdog_err=1 at cycle 50 in WAIT,
//     stays 1; rst pulse mid-WAIT -> all outputs to reset values next edge.

Source files
------------

// File: rtl/debounce_ctrl.sv
// Debouncer that arms an external timer when the synchronised input changes and
// commits the new level only if the input holds until the timer reports expiry.
module debounce_ctrl #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_LEVEL = 1'b0,
  parameter int   GLITCH_W    = 8,
  parameter int   WDOG_LIMIT  = 65535,
  parameter int   WDOG_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                raw_in,
  output logic                tmr_start,
  input  logic                tmr_done,
  output logic                clean_out,
  output logic                rise_pulse,
  output logic                fall_pulse,
  output logic [GLITCH_W-1:0] glitch_cnt,
  output logic                wdog_err
);

  typedef enum logic [1:0] {
    ST_STABLE = 2'd0,
    ST_WAIT   = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

  localparam bit              WDOG_EN   = (WDOG_LIMIT != 0);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_LIMIT - 1);

  state_e                state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                  tmr_done_q, tmr_done_d;
  logic                  tmr_start_q, tmr_start_d;
  logic                  clean_out_q, clean_out_d;
  logic                  rise_pulse_q, rise_pulse_d;
  logic                  fall_pulse_q, fall_pulse_d;
  logic [GLITCH_W-1:0]   glitch_cnt_q, glitch_cnt_d;
  logic                  wdog_err_q, wdog_err_d;
  logic [WDOG_W-1:0]     wdog_cnt_q, wdog_cnt_d;

  logic                  sync_in;
  logic                  done_ev;
  logic                  differs;
  logic                  wdog_hit;
  logic [GLITCH_W-1:0]   glitch_inc;

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], raw_in};
    tmr_done_d = tmr_done;
    sync_in    = sync_q[SYNC_STAGES-1];
    done_ev    = tmr_done & ~tmr_done_q;
    differs    = (sync_in != clean_out_q);
    wdog_hit   = WDOG_EN && (state_q != ST_STABLE) && (wdog_cnt_q == WDOG_LAST);
    glitch_inc = (&glitch_cnt_q) ? glitch_cnt_q : glitch_cnt_q + GLITCH_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_STABLE;
      sync_q       <= {SYNC_STAGES{RESET_LEVEL}};
      tmr_done_q   <= 1'b0;
      tmr_start_q  <= 1'b0;
      clean_out_q  <= RESET_LEVEL;
      rise_pulse_q <= 1'b0;
      fall_pulse_q <= 1'b0;
      glitch_cnt_q <= '0;
      wdog_err_q   <= 1'b0;
      wdog_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      tmr_done_q   <= tmr_done_d;
      tmr_start_q  <= tmr_start_d;
      clean_out_q  <= clean_out_d;
      rise_pulse_q <= rise_pulse_d;
      fall_pulse_q <= fall_pulse_d;
      glitch_cnt_q <= glitch_cnt_d;
      wdog_err_q   <= wdog_err_d;
      wdog_cnt_q   <= wdog_cnt_d;
    end
  end

  // A reverted input without a same-cycle expiry must drain the outstanding timer run.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STABLE: if (differs) state_d = ST_WAIT;
      ST_WAIT: begin
        if (done_ev || wdog_hit) state_d = ST_STABLE;
        else if (!differs)       state_d = ST_DRAIN;
      end
      ST_DRAIN: if (done_ev || wdog_hit) state_d = ST_STABLE;
      default: state_d = ST_STABLE;
    endcase
  end

  always_comb begin
    tmr_start_d  = 1'b0;
    rise_pulse_d = 1'b0;
    fall_pulse_d = 1'b0;
    clean_out_d  = clean_out_q;
    glitch_cnt_d = glitch_cnt_q;
    wdog_err_d   = wdog_err_q;
    wdog_cnt_d   = wdog_cnt_q;
    case (state_q)
      ST_STABLE: begin
        if (differs) begin
          tmr_start_d = 1'b1;
          wdog_cnt_d  = '0;
        end
      end
      ST_WAIT: begin
        wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
        if (!differs) begin
          glitch_cnt_d = glitch_inc;
        end else if (done_ev) begin
          clean_out_d  = sync_in;
          rise_pulse_d = sync_in;
          fall_pulse_d = ~sync_in;
        end
        if (!done_ev && wdog_hit) wdog_err_d = 1'b1;
      end
      ST_DRAIN: begin
        wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
        if (!done_ev && wdog_hit) wdog_err_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign tmr_start  = tmr_start_q;
  assign clean_out  = clean_out_q;
  assign rise_pulse = rise_pulse_q;
  assign fall_pulse = fall_pulse_q;
  assign glitch_cnt = glitch_cnt_q;
  assign wdog_err   = wdog_err_q;

endmodule
